// File: rtl/clock_strobe_gen.sv
// clock_strobe_gen: multi-channel clock-enable generator with shadowed divisors (optional macro CSG_DEBUG_CNT_EN adds a channel-0 strobe counter)
module clock_strobe_gen #(
    parameter  int CHANNELS    = 2,
    parameter  int CNT_W       = 16,
    parameter  int DEFAULT_DIV = 200,
    localparam int CH_W        = (CHANNELS > 1 ? $clog2(CHANNELS) : 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync_restart,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] cfg_pending,
    output logic [CHANNELS-1:0] strobe,
    output logic [CHANNELS-1:0] strobe_180,
    output logic [CHANNELS-1:0] clk_level,
    output logic [31:0]         debug_count
);
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d, div_act_q, div_act_d, div_pend_q, div_pend_d;
    logic [CHANNELS-1:0] pend_q, pend_d, strobe_q, strobe_d, s180_q, s180_d, lvl_q, lvl_d;
    logic [CHANNELS-1:0] wr_hit, wrap, run, apply, bypass;
    logic [CNT_W-1:0] div_clamp;
    logic wr_valid;

    assign div_clamp = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
    assign wr_valid  = cfg_wr && (32'(cfg_chan) < 32'(CHANNELS));

    // per-channel counter, output decode and divisor shadow/apply logic
    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        strobe_d   = '0;
        s180_d     = '0;
        lvl_d      = '0;
        wr_hit     = '0;
        wrap       = '0;
        run        = '0;
        apply      = '0;
        bypass     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i]     = wr_valid && (cfg_chan == CH_W'(i));
            wrap[i]       = cnt_q[i] == div_act_q[i] - CNT_W'(1);
            run[i]        = enable[i] && !sync_restart;
            apply[i]      = !run[i] || wrap[i];
            bypass[i]     = run[i] && wrap[i] && wr_hit[i];
            cnt_d[i]      = apply[i] ? '0 : cnt_q[i] + CNT_W'(1);
            strobe_d[i]   = run[i] && (cnt_q[i] == '0);
            s180_d[i]     = run[i] && (cnt_q[i] == (div_act_q[i] >> 1));
            lvl_d[i]      = run[i] && (cnt_q[i] < (div_act_q[i] >> 1));
            div_pend_d[i] = wr_hit[i] ? div_clamp : div_pend_q[i];
            div_act_d[i]  = bypass[i] ? div_clamp : apply[i] ? div_pend_q[i] : div_act_q[i];
            pend_d[i]     = !bypass[i] && (wr_hit[i] || (pend_q[i] && !apply[i]));
        end
    end

    // channel state registers; reset drops any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            div_act_q  <= {CHANNELS{CNT_W'(DEFAULT_DIV)}};
            div_pend_q <= {CHANNELS{CNT_W'(DEFAULT_DIV)}};
            pend_q     <= '0;
            strobe_q   <= '0;
            s180_q     <= '0;
            lvl_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            strobe_q   <= strobe_d;
            s180_q     <= s180_d;
            lvl_q      <= lvl_d;
        end
    end

    assign cfg_pending = pend_q;
    assign strobe      = strobe_q;
    assign strobe_180  = s180_q;
    assign clk_level   = lvl_q;

`ifdef CSG_DEBUG_CNT_EN
    logic [31:0] dbg_q, dbg_d;

    // count channel-0 strobes, restarting with the channels on sync_restart
    always_comb dbg_d = sync_restart ? '0 : dbg_q + 32'(strobe_q[0]);

    // debug counter register
    always_ff @(posedge clk) begin
        if (reset) dbg_q <= '0;
        else       dbg_q <= dbg_d;
    end

    assign debug_count = dbg_q;
`else
    assign debug_count = '0;
`endif
endmodule

// File: tb/tb_clock_strobe_gen.sv
// tb_clock_strobe_gen: directed checks of strobe timing, divisor shadowing, clamping, restart and reset
module tb_clock_strobe_gen;
    localparam int N = 3;
    localparam int W = 16;
`ifdef CSG_DEBUG_CNT_EN
    localparam logic [31:0] DBG_ONE = 32'd1;
`else
    localparam logic [31:0] DBG_ONE = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset, sync_restart, cfg_wr;
    logic [N-1:0] enable, cfg_pending, strobe, strobe_180, clk_level;
    logic [1:0] cfg_chan;
    logic [W-1:0] cfg_div;
    logic [31:0] debug_count;
    int vectors = 0;
    int miscompares = 0;

    clock_strobe_gen #(.CHANNELS(N), .CNT_W(W), .DEFAULT_DIV(200)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sync_restart(sync_restart),
        .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_div(cfg_div),
        .cfg_pending(cfg_pending), .strobe(strobe), .strobe_180(strobe_180),
        .clk_level(clk_level), .debug_count(debug_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ch(input int ch, input int t, input int d);
        int ph;
        logic [2:0] e;
        if (d < 0) return;
        ph = (d == 0) ? 0 : (t - 1) % d;
        e = (d == 0) ? 3'b000 : {ph == 0, ph == d / 2, ph < d / 2};
        chk($sformatf("ch%0d_t%0d_div%0d", ch, t, d), {29'd0, strobe[ch], strobe_180[ch], clk_level[ch]}, {29'd0, e});
    endtask

    task automatic run(input int n, input int d0, input int d1);
        for (int t = 1; t <= n; t++) begin
            tick();
            chk_ch(0, t, d0);
            chk_ch(1, t, d1);
            chk_ch(2, t, 0);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [W-1:0] d);
        cfg_wr = 1'b1;
        cfg_chan = ch;
        cfg_div = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_strobe"}, 32'(strobe), 32'd0);
        chk({tag, "_s180"}, 32'(strobe_180), 32'd0);
        chk({tag, "_level"}, 32'(clk_level), 32'd0);
        chk({tag, "_pending"}, 32'(cfg_pending), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = '0; sync_restart = 1'b0; cfg_wr = 1'b0; cfg_chan = '0; cfg_div = '0;
        tick(); tick();
        chk_idle("reset");
        chk("reset_dbg", debug_count, 32'd0);
        reset = 1'b0;
        enable = 3'b001;
        run(200, 200, 0);
        repeat (50) tick();
        wr(2'd0, 16'd10);
        chk("pend_set", 32'(cfg_pending), 32'd1);
        repeat (148) tick();
        chk("pend_hold", 32'(cfg_pending), 32'd1);
        tick();
        chk("pend_clear", 32'(cfg_pending), 32'd0);
        run(20, 10, 0);
        repeat (9) tick();
        wr(2'd0, 16'd4);
        chk("bypass_pend", 32'(cfg_pending), 32'd0);
        run(8, 4, 0);
        wr(2'd0, 16'd0);
        chk("div0_pend", 32'(cfg_pending), 32'd1);
        repeat (3) tick();
        chk("div0_applied", 32'(cfg_pending), 32'd0);
        run(6, 2, 0);
        wr(2'd0, 16'd1);
        chk("div1_pend", 32'(cfg_pending), 32'd1);
        tick();
        chk("div1_applied", 32'(cfg_pending), 32'd0);
        run(6, 2, 0);
        wr(2'd0, 16'd5);
        tick();
        run(10, 5, 0);
        wr(2'd1, 16'd3);
        wr(2'd0, 16'd7);
        enable = 3'b011;
        sync_restart = 1'b1;
        tick();
        sync_restart = 1'b0;
        chk_idle("sync1");
        run(21, 7, 3);
        repeat (5) tick();
        sync_restart = 1'b1;
        tick();
        sync_restart = 1'b0;
        chk_idle("sync2");
        chk("sync2_dbg", debug_count, 32'd0);
        tick();
        chk("sync2_together", 32'(strobe), 32'd3);
        chk("sync2_dbg_hold", debug_count, 32'd0);
        tick();
        chk("sync2_dbg_one", debug_count, DBG_ONE);
        wr(2'd3, 16'd9);
        chk("bad_chan_pend", 32'(cfg_pending), 32'd0);
        repeat (4) tick();
        run(7, 7, -1);
        wr(2'd0, 16'd9);
        chk("pre_reset_pend", 32'(cfg_pending), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("midreset");
        chk("midreset_dbg", debug_count, 32'd0);
        run(201, 200, 200);
        repeat (30) tick();
        enable = 3'b001;
        run(5, -1, 0);
        enable = 3'b011;
        run(201, -1, 200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clock_strobe_gen.md
Name: clock_strobe_gen

Overview:
- Parametrised multi-channel clock-enable generator.
- Replaces the hand-coded clk/250 kHz counter logic in the top level: CHANNELS independent divider channels, each producing a one-cycle strobe, a half-period (180°) strobe, and a square-wave level.
- Divisors are runtime-programmable with glitch-free shadow update.
- A global sync restart phase-aligns all channels.
- All outputs are synchronous enables in the clk domain; no derived clocks.

Parameters:
- CHANNELS, 2, number of independent divider channels (1..16).
- CNT_W, 16, divisor/counter width in bits.
- DEFAULT_DIV, 200, divisor loaded into every channel at reset (50 MHz / 200 = 250 kHz).
- CH_W, (CHANNELS>1 ? $clog2(CHANNELS) : 1), channel-select width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  CHANNELS  per-channel run enable.
- sync_restart  in  1  one-cycle pulse: restart all channels at phase 0.
- cfg_wr  in  1  divisor write strobe.
- cfg_chan  in  CH_W  target channel for cfg_wr.
- cfg_div  in  CNT_W  new divisor value.
- cfg_pending  out  CHANNELS  written divisor not yet applied.
- strobe  out  CHANNELS  one-cycle pulse at phase 0.
- strobe_180  out  CHANNELS  one-cycle pulse at phase div/2.
- clk_level  out  CHANNELS  square wave, high for the first floor(div/2) cycles of each period.
- debug_count  out  32  strobe counter for channel 0 (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Per-channel state:
  - cnt[CNT_W], div_act[CNT_W], div_pend[CNT_W], pend bit.
  - All outputs are registered.
- Reset (sampled at a clk edge):
  - cnt=0; div_act=div_pend=DEFAULT_DIV; pend=0.
  - strobe, strobe_180, clk_level, cfg_pending all 0; debug_count=0.
  - Reset mid-period discards any pending write.
- Counting, at each edge with enable[i]=1:
  - cnt <= (cnt==div_act-1) ? 0 : cnt+1.
  - strobe[i] <= (cnt==0).
  - strobe_180[i] <= (cnt==div_act>>1).
  - clk_level[i] <= (cnt < div_act>>1).
- Latency:
  - The strobe appears one cycle after the edge that samples cnt==0 with enable high.
  - Period is exactly div_act cycles.
- Disable, at an edge with enable[i]=0:
  - cnt <= 0; all three outputs <= 0.
  - A pending divisor is applied immediately.
  - On re-enable, the first strobe comes one cycle after the first enabled edge.
- Divisor write (cfg_wr=1):
  - div_pend[cfg_chan] <= max(cfg_div, 2). Values 0 and 1 are clamped to 2.
  - pend <= 1.
  - cfg_chan >= CHANNELS: write ignored, no state changes.
- Apply:
  - At the wrap edge (cnt==div_act-1, enabled) or while disabled: div_act <= div_pend, pend <= 0.
  - cfg_wr on the target channel's wrap edge bypasses the shadow: div_act <= clamped cfg_div, pend stays 0.
  - A second write before apply overwrites div_pend (last write wins).
- sync_restart=1:
  - Every channel: cnt <= 0; outputs <= 0; pending divisor applied.
  - Enabled channels then strobe together one cycle later.
  - sync_restart has priority over cfg_wr bypass and counting. A cfg_wr in the same cycle lands in div_pend with pend=1.
- Width rules:
  - Comparisons use div_act-1 and div_act>>1 at CNT_W bits.
  - div=2 gives alternating strobe/strobe_180.
  - Odd div: strobe_180 at floor(div/2).
  - Max div = 2^CNT_W-1.
- Channels are fully independent except for sync_restart and debug_count.

Optional Feature:
- Macro CSG_DEBUG_CNT_EN.
- Defined: debug_count increments (mod 2^32) on every cycle strobe[0]=1. It clears on reset and on sync_restart.
- Not defined: debug_count is constant 0 and the counter logic is absent. The port always exists.

Test Plan:
- Reset, enable=2'b01, DEFAULT_DIV=200 -> strobe[0] pulses every 200 cycles, first pulse 1 cycle after the first enabled edge. strobe_180[0] 100 cycles after each strobe. clk_level[0] high 100 cycles, low 100 cycles. Channel 1 outputs stay 0.
- cfg_wr chan0 div=10 at cnt=50 -> cfg_pending[0]=1 until the wrap at cnt=199. Next period is 10 cycles, then pending clears. A cfg_wr on the wrap edge applies with no pending.
- cfg_wr div=0 and div=1 -> both behave as div=2: strobe and strobe_180 alternate each cycle. div=5 -> strobe_180 at phase 2, clk_level high 2 of 5 cycles.
- Ch0 div=7, ch1 div=3 free-running, then sync_restart -> both strobes coincide 1 cycle after the edge following sync_restart. With the macro defined, debug_count returns to 0.
- cfg_chan=3 with CHANNELS=2 -> no state change. Reset asserted mid-period with a pending write -> div_act=200, cfg_pending=0, all outputs 0.
- Toggle enable[1] low for 5 cycles mid-period -> outputs 0 while low. On re-enable, strobe[1] fires 1 cycle after the first high edge; period unchanged.
